// File: rtl/pc_ir_unit_if.sv
// Bus between the multicycle controller/datapath and the PC/IR unit.
`timescale 1ns/1ps
interface pc_ir_unit_if;
  // Controller strobes and selects
  logic        pcen;
  logic        irwrite;
  logic        iord;
  logic [1:0]  pcsrc;
  // Datapath and memory operands
  logic [31:0] aluresult;
  logic [31:0] aluout;
  logic [31:0] readdata;
  // Unit results
  logic [31:0] adr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] data;
  logic [15:0] instcount;

  // Controller/datapath side
  modport master (
    output pcen, irwrite, iord, pcsrc, aluresult, aluout, readdata,
    input  adr, pc, instr, op, funct, data, instcount
  );

  // PC/IR unit side
  modport slave (
    input  pcen, irwrite, iord, pcsrc, aluresult, aluout, readdata,
    output adr, pc, instr, op, funct, data, instcount
  );
endinterface

// File: rtl/pc_ir_unit.sv
// Program counter, instruction register, memory data register and fetch
// counter for a multicycle MIPS-style datapath.
`timescale 1ns/1ps
module pc_ir_unit (
  input  logic         clk,
  input  logic         reset,
  pc_ir_unit_if.slave  bus
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned FIELD_W  = 6;
  localparam int unsigned JIDX_W   = 26;
  localparam int unsigned PCHI_W   = 4;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  instr_q;
  logic [XLEN-1:0]  data_q;
  logic [CNT_W-1:0] count_q;

  logic [XLEN-1:0]  jump_target;
  logic [XLEN-1:0]  pc_next;

  // Jump target built from the current (pre-edge) PC and IR contents
  assign jump_target = {pc_q[XLEN-1 -: PCHI_W], instr_q[JIDX_W-1:0], 2'b00};

  // Next-PC select
  always_comb begin
    pc_next = pc_q;
    case (bus.pcsrc)
      PCSRC_ALU:    pc_next = bus.aluresult;
      PCSRC_ALUOUT: pc_next = bus.aluout;
      PCSRC_JUMP:   pc_next = jump_target;
      PCSRC_HOLD:   pc_next = pc_q;
      default:      pc_next = pc_q;
    endcase
  end

  // Program counter, loaded only on pcen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else if (bus.pcen) begin
      pc_q <= pc_next;
    end
  end

  // Instruction register, loaded only on irwrite
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
    end else if (bus.irwrite) begin
      instr_q <= bus.readdata;
    end
  end

  // Memory data register, captures read data every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= bus.readdata;
    end
  end

  // Fetch counter, saturates instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (bus.irwrite && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Address mux is combinational so memory sees the address this cycle
  assign bus.adr       = bus.iord ? bus.aluout : pc_q;
  assign bus.pc        = pc_q;
  assign bus.instr     = instr_q;
  assign bus.op        = instr_q[XLEN-1 -: FIELD_W];
  assign bus.funct     = instr_q[FIELD_W-1:0];
  assign bus.data      = data_q;
  assign bus.instcount = count_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit with hand-computed expectations.
`timescale 1ns/1ps
module tb_pc_ir_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pc_ir_unit_if bus ();

  pc_ir_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b0;
    bus.pcen      = 1'b0;
    bus.irwrite   = 1'b0;
    bus.iord      = 1'b0;
    bus.pcsrc     = 2'b00;
    bus.aluresult = 32'h0;
    bus.aluout    = 32'h0;
    bus.readdata  = 32'h0;

    // Reset state
    step();
    chk("rst_pc",    bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_data",  bus.data, 32'h0);
    chk("rst_cnt",   32'(bus.instcount), 32'h0);
    chk("rst_op",    32'(bus.op), 32'h0);
    chk("rst_funct", 32'(bus.funct), 32'h0);
    chk("rst_adr",   bus.adr, 32'h0);
    #3 reset = 1'b1;

    // Fetch
    step();
    bus.pcen = 1'b1; bus.irwrite = 1'b1; bus.pcsrc = 2'b00;
    bus.aluresult = 32'h4; bus.readdata = 32'h8C020004;
    step();
    chk("fetch_pc",    bus.pc, 32'h4);
    chk("fetch_instr", bus.instr, 32'h8C020004);
    chk("fetch_op",    32'(bus.op), 32'h23);
    chk("fetch_funct", 32'(bus.funct), 32'h04);
    chk("fetch_cnt",   32'(bus.instcount), 32'h1);
    chk("fetch_data",  bus.data, 32'h8C020004);

    // Set up jump: pc=40000010, instr=08000005
    bus.aluresult = 32'h40000010; bus.readdata = 32'h08000005;
    step();
    chk("setup_pc",    bus.pc, 32'h40000010);
    chk("setup_instr", bus.instr, 32'h08000005);

    // Jump with simultaneous IR load: target uses the old instr
    bus.pcsrc = 2'b10; bus.readdata = 32'h08000010;
    step();
    chk("jump_pc",    bus.pc, 32'h40000014);
    chk("jump_instr", bus.instr, 32'h08000010);
    chk("jump_cnt",   32'(bus.instcount), 32'h3);

    // Jump using the newly loaded instr
    bus.irwrite = 1'b0;
    step();
    chk("jump2_pc",    bus.pc, 32'h40000040);
    chk("jump2_op",    32'(bus.op), 32'h02);
    chk("jump2_funct", 32'(bus.funct), 32'h10);

    // pcsrc=01 loads aluout, pcsrc=11 holds
    bus.pcsrc = 2'b01; bus.aluout = 32'h00000100;
    step();
    chk("aluout_pc", bus.pc, 32'h100);
    bus.pcsrc = 2'b11; bus.aluout = 32'h00000200; bus.aluresult = 32'h300;
    step();
    chk("hold11_pc", bus.pc, 32'h100);

    // Hold with enables low; MDR follows readdata one edge later
    bus.pcen = 1'b0; bus.pcsrc = 2'b00; bus.aluresult = 32'hDEADBEEF;
    bus.readdata = 32'hA5A5A5A5;
    #1 chk("mdr_lat0", bus.data, 32'h08000010);
    step();
    chk("hold_data0",  bus.data, 32'hA5A5A5A5);
    chk("hold_pc0",    bus.pc, 32'h100);
    chk("hold_instr0", bus.instr, 32'h08000010);
    bus.readdata = 32'h5A5A5A5A;
    #1 chk("mdr_lat1", bus.data, 32'hA5A5A5A5);
    step();
    chk("hold_data1", bus.data, 32'h5A5A5A5A);
    bus.readdata = 32'h12345678;
    step();
    chk("hold_data2",  bus.data, 32'h12345678);
    chk("hold_pc2",    bus.pc, 32'h100);
    chk("hold_instr2", bus.instr, 32'h08000010);
    chk("hold_cnt",    32'(bus.instcount), 32'h3);

    // Address mux, same cycle
    bus.iord = 1'b1; bus.aluout = 32'h0000003C;
    #1 chk("adr_aluout", bus.adr, 32'h3C);
    bus.iord = 1'b0;
    #1 chk("adr_pc", bus.adr, 32'h100);

    // Async reset between edges with pc=20
    step();
    bus.pcen = 1'b1; bus.pcsrc = 2'b00; bus.aluresult = 32'h20;
    step();
    chk("pre_rst_pc", bus.pc, 32'h20);
    bus.pcen = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_pc",    bus.pc, 32'h0);
    chk("arst_instr", bus.instr, 32'h0);
    chk("arst_cnt",   32'(bus.instcount), 32'h0);
    chk("arst_data",  bus.data, 32'h0);
    chk("arst_adr",   bus.adr, 32'h0);
    // Loads requested during reset are discarded
    bus.pcen = 1'b1; bus.irwrite = 1'b1; bus.readdata = 32'hFFFFFFFF;
    step();
    chk("rst_fetch_pc",    bus.pc, 32'h0);
    chk("rst_fetch_instr", bus.instr, 32'h0);
    chk("rst_fetch_cnt",   32'(bus.instcount), 32'h0);
    bus.pcen = 1'b0; bus.irwrite = 1'b0;
    #3 reset = 1'b1;

    // Saturation of the fetch counter
    step();
    bus.irwrite = 1'b1;
    repeat (65534) step();
    chk("sat_fffe", 32'(bus.instcount), 32'h0000FFFE);
    step();
    chk("sat_ffff", 32'(bus.instcount), 32'h0000FFFF);
    step();
    chk("sat_hold", 32'(bus.instcount), 32'h0000FFFF);
    chk("sat_pc",   bus.pc, 32'h0);
    bus.irwrite = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 SHALL have clk, input, 1, single rising-edge clock.
REQ-002 SHALL have reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have pcen, input, 1, PC load enable from controller.
REQ-004 SHALL have irwrite, input, 1, instruction register load enable from controller.
REQ-005 SHALL have iord, input, 1, address select: 0 = PC, 1 = aluout.
REQ-006 SHALL have pcsrc, input, 2, next-PC select.
REQ-007 SHALL have aluresult, input, 32, combinational ALU result from datapath.
REQ-008 SHALL have aluout, input, 32, registered ALU result from datapath.
REQ-009 SHALL have readdata, input, 32, memory read data.
REQ-010 SHALL have adr, output, 32, memory address.
REQ-011 SHALL have pc, output, 32, current PC register.
REQ-012 SHALL have instr, output, 32, instruction register.
REQ-013 SHALL have op, output, 6, instr[31:26] to controller.
REQ-014 SHALL have funct, output, 6, instr[5:0] to controller.
REQ-015 SHALL have data, output, 32, memory data register (MDR).
REQ-016 SHALL have instcount, output, 16, count of instruction fetches.

Function
REQ-017 SHALL drive adr combinationally: iord=0 -> pc; iord=1 -> aluout.
REQ-018 SHALL compute next PC: pcsrc 00 -> aluresult; 01 -> aluout; 10 -> {pc[31:28], instr[25:0], 2'b00}; 11 -> pc (hold).
REQ-019 SHALL load pc with next PC on a rising clk edge only when pcen=1; otherwise hold.
REQ-020 SHALL load instr with readdata on a rising clk edge only when irwrite=1; otherwise hold.
REQ-021 SHALL load data with readdata on every rising clk edge, no enable (one-cycle latency).
REQ-022 SHALL drive op and funct as pure slices of the instr register; new values are visible the cycle after the irwrite edge.
REQ-023 SHALL compute the jump target from the pre-edge pc and instr values when pcen and irwrite are both 1 on the same edge; both registers update on that edge.
REQ-024 SHALL increment instcount by 1 on each edge with irwrite=1, saturating at 16'hFFFF without wrap.
REQ-025 SHALL never write any register except on a rising clk edge or on reset assertion.
REQ-026 SHALL ignore pcsrc when pcen=0, and ignore iord for all sequential state.

Reset
REQ-027 SHALL, while reset=0, force pc=32'h0, instr=32'h0, data=32'h0, instcount=16'h0 immediately, without waiting for a clk edge.
REQ-028 SHALL resume normal operation on the first rising clk edge after reset returns to 1; reset asserted mid-fetch discards any pending load.
REQ-029 SHALL produce op=6'h0, funct=6'h0, and adr=32'h0 (when iord=0) during reset.

Verification
REQ-030 Fetch: reset release, pcen=1, irwrite=1, pcsrc=00, aluresult=32'h4, readdata=32'h8C020004, one edge -> pc=4, instr=32'h8C020004, op=6'h23, instcount=1.
REQ-031 Jump: pc=32'h40000010, instr=32'h08000005, pcsrc=10, pcen=1, one edge -> pc=32'h40000014.
REQ-032 Hold: pcen=0, irwrite=0, readdata toggled for 3 edges -> pc and instr unchanged; data tracks readdata with one-cycle latency.
REQ-033 Address mux: iord=1, aluout=32'h0000003C -> adr=32'h3C in the same cycle; iord=0 -> adr=pc.
REQ-034 Saturation: instcount preset by 65535 irwrite edges, one more irwrite edge -> instcount stays 16'hFFFF.
REQ-035 Async reset: reset driven to 0 between clk edges with pc=32'h20 -> pc=0, instr=0, instcount=0 before the next edge.
